fractal_coord_gen: RTL

Upstream pixel scheduler for the Mandelbrot divergence pipeline. It walks an H_RES×V_RES frame in raster order and issues one complex coordinate (c_re, c_im) into pipeline stage 0 every ISSUE_DIV clocks. It carries each pixel's frame-buffer address through a PIPE_DEPTH-deep delay line, so wr_addr and wr_en line up exactly with the iteration count leaving the last pipeline stage. At end of frame it raises read_enable so the VGA bitmap reader can start scanning the buffer.

---
 rtl/fractal_coord_gen_if.sv | 13 +
 rtl/fractal_coord_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fractal_coord_gen_if.sv
// fractal_coord_gen_if: frame request inputs and the pixel / write-strobe outputs of the coordinate generator.
interface fractal_coord_gen_if #(parameter int ADDR_W = 19);
    logic              start;
    logic [15:0]       startX, startY, stepX, stepY;
    logic [15:0]       c_re, c_im;
    logic              c_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en, busy, frame_done, read_enable;
    modport master (output start, startX, startY, stepX, stepY,
                    input c_re, c_im, c_valid, wr_addr, wr_en, busy, frame_done, read_enable);
    modport slave (input start, startX, startY, stepX, stepY,
                   output c_re, c_im, c_valid, wr_addr, wr_en, busy, frame_done, read_enable);
endinterface

// File: rtl/fractal_coord_gen.sv
// fractal_coord_gen: raster-order Mandelbrot coordinate issuer with a frame-buffer address
// delay line aligned to the divergence pipeline latency.
module fractal_coord_gen #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PIPE_DEPTH = 62,
    parameter int ISSUE_DIV  = 6,
    parameter int ADDR_W     = 19
) (
    input  logic               Clk_100M,
    input  logic               reset,
    fractal_coord_gen_if.slave bus
);
    localparam int CW = $clog2(H_RES + 1);
    localparam int RW = $clog2(V_RES + 1);
    localparam int TW = $clog2(ISSUE_DIV + 1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(H_RES - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(V_RES - 1);
    localparam logic [TW-1:0]     TICK_LAST = TW'(ISSUE_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] a;
    } dl_t;

    state_t            state_q, state_d;
    logic [15:0]       sx_q, sx_d, dx_q, dx_d, dy_q, dy_d;
    logic [15:0]       re_q, re_d, im_q, im_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d, pix_addr_q, pix_addr_d;
    logic [15:0]       c_re_q, c_re_d, c_im_q, c_im_d;
    logic              c_valid_q, c_valid_d, busy_q, busy_d;
    logic              frame_done_q, frame_done_d, read_enable_q, read_enable_d;
    dl_t               dl_q [PIPE_DEPTH];
    dl_t               dl_d [PIPE_DEPTH];
    logic              go, issue, last_col;
    logic [15:0]       re, im;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [TW-1:0]     tick;
    logic [ADDR_W-1:0] addr;

    // On an accepted start the fresh inputs stand in for the latched ones, so the
    // start edge itself counts as tick 0 of the first pixel.
    always_comb begin
        go            = state_q == IDLE && bus.start;
        sx_d          = go ? bus.startX : sx_q;
        dx_d          = go ? bus.stepX : dx_q;
        dy_d          = go ? bus.stepY : dy_q;
        re            = go ? bus.startX : re_q;
        im            = go ? bus.startY : im_q;
        col           = go ? '0 : col_q;
        row           = go ? '0 : row_q;
        addr          = go ? '0 : addr_q;
        tick          = go ? '0 : tick_q;
        issue         = (go || state_q == ISSUE) && tick == TICK_LAST;
        last_col      = col == COL_LAST;
        tick_d        = issue ? '0 : tick + TW'(1);
        re_d          = issue ? (last_col ? sx_d : re + dx_d) : re;
        im_d          = issue && last_col ? im + dy_d : im;
        col_d         = issue ? (last_col ? '0 : col + CW'(1)) : col;
        row_d         = issue && last_col ? row + RW'(1) : row;
        addr_d        = issue ? addr + ADDR_W'(1) : addr;
        c_re_d        = issue ? re : c_re_q;
        c_im_d        = issue ? im : c_im_q;
        pix_addr_d    = issue ? addr : pix_addr_q;
        c_valid_d     = issue;
        state_d       = issue && last_col && row == ROW_LAST ? DRAIN
                      : go ? ISSUE
                      : state_q == DRAIN && dl_q[PIPE_DEPTH-1].v && dl_q[PIPE_DEPTH-1].a == ADDR_LAST ? DONE
                      : state_q == DONE ? IDLE
                      : state_q;
        busy_d        = state_d == ISSUE || state_d == DRAIN;
        frame_done_d  = state_d == DONE;
        read_enable_d = read_enable_q || frame_done_d;
        dl_d[0]       = {c_valid_q, pix_addr_q};
        for (int i = 1; i < PIPE_DEPTH; i++) dl_d[i] = dl_q[i-1];
    end

    always_ff @(posedge Clk_100M or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sx_q          <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            re_q          <= '0;
            im_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            tick_q        <= '0;
            addr_q        <= '0;
            pix_addr_q    <= '0;
            c_re_q        <= '0;
            c_im_q        <= '0;
            c_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            read_enable_q <= 1'b0;
            dl_q          <= '{default: '0};
        end else begin
            state_q       <= state_d;
            sx_q          <= sx_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            re_q          <= re_d;
            im_q          <= im_d;
            col_q         <= col_d;
            row_q         <= row_d;
            tick_q        <= tick_d;
            addr_q        <= addr_d;
            pix_addr_q    <= pix_addr_d;
            c_re_q        <= c_re_d;
            c_im_q        <= c_im_d;
            c_valid_q     <= c_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            read_enable_q <= read_enable_d;
            dl_q          <= dl_d;
        end
    end

    assign bus.c_re        = c_re_q;
    assign bus.c_im        = c_im_q;
    assign bus.c_valid     = c_valid_q;
    assign bus.wr_addr     = dl_q[PIPE_DEPTH-1].a;
    assign bus.wr_en       = dl_q[PIPE_DEPTH-1].v;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.read_enable = read_enable_q;
endmodule
